uart_frame_rx: RTL and testbench

Downstream consumer of the `uart` receive path. Pops bytes through the `uart` rx request/ready handshake, hunts for a sync byte, and checks a length-prefixed, checksummed frame. Buffers the payload internally. Forwards the payload on a valid/ready byte stream only after the checksum passes, so corrupted frames never reach the command logic.

---
 rtl/uart_frame_pkg.sv | 19 +
 rtl/uart_frame_buf.sv | 25 ++
 rtl/uart_frame_rx.sv | 184 ++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the uart_frame_rx receive path.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_PAYLOAD,
        ST_CSUM,
        ST_OUT
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store: DEPTH x 8 registers, synchronous write, combinational read.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [DEPTH];

    // Contents are deliberately not reset; only indices that were written get read.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/uart_frame_rx.sv
// Framed receiver: hunts for a sync byte, checks length and checksum, and
// forwards the buffered payload only when the frame is good.
// Optional inter-byte timeout is enabled with `define UART_FRAME_TIMEOUT_EN.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int          MAX_LEN        = 16,
    parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    output logic       uart_rx_req,
    input  logic       uart_rx_ready,
    input  logic [7:0] uart_rx_data,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code
);

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_e        state_q, state_d;
    logic [IW-1:0] len_q, len_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          frame_ok_q, frame_ok_d;
    logic          frame_err_q, frame_err_d;

    logic          accept;
    logic          buf_wr_en;
    logic [7:0]    buf_rd_data;
    logic [7:0]    csum_total;

`ifdef UART_FRAME_TIMEOUT_EN
    logic [15:0]   tmo_q, tmo_d;
`else
    logic          unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign uart_rx_req = (state_q != ST_OUT);
    assign accept      = uart_rx_req && uart_rx_ready;
    assign buf_wr_en   = accept && (state_q == ST_PAYLOAD);
    assign csum_total  = sum_q + uart_rx_data;

    assign m_valid   = (state_q == ST_OUT);
    assign m_data    = m_valid ? buf_rd_data : 8'h00;
    assign m_last    = m_valid && (rd_idx_q == len_q - IW'(1));
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk       (clk),
        .wr_en_i   (buf_wr_en),
        .wr_addr_i (wr_idx_q[AW-1:0]),
        .wr_data_i (uart_rx_data),
        .rd_addr_i (rd_idx_q[AW-1:0]),
        .rd_data_o (buf_rd_data)
    );

    // Frame parser: decides next state, bookkeeping and the status pulses.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        sum_d       = sum_q;
        err_code_d  = err_code_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (accept && uart_rx_data == SYNC_BYTE) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    if (uart_rx_data == 8'd0 || int'(uart_rx_data) > MAX_LEN) begin
                        state_d     = ST_HUNT;
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_LEN;
                    end else begin
                        len_d    = IW'(uart_rx_data);
                        sum_d    = uart_rx_data;
                        wr_idx_d = '0;
                        state_d  = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    wr_idx_d = wr_idx_q + IW'(1);
                    sum_d    = csum_total;
                    if (wr_idx_q + IW'(1) == len_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (csum_total == 8'd0) begin
                        frame_ok_d = 1'b1;
                        rd_idx_d   = '0;
                        state_d    = ST_OUT;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_CSUM;
                        state_d     = ST_HUNT;
                    end
                end
            end
            ST_OUT: begin
                if (m_ready) begin
                    rd_idx_d = rd_idx_q + IW'(1);
                    if (m_last) begin
                        state_d = ST_HUNT;
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

`ifdef UART_FRAME_TIMEOUT_EN
        tmo_d = '0;
        if (state_q == ST_LEN || state_q == ST_PAYLOAD || state_q == ST_CSUM) begin
            if (accept) begin
                tmo_d = '0;
            end else if (tmo_q == TIMEOUT_CYCLES - 16'd1) begin
                state_d     = ST_HUNT;
                frame_err_d = 1'b1;
                err_code_d  = ERR_TIMEOUT;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end
`endif
    end

    // State and bookkeeping registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_HUNT;
            len_q       <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            sum_q       <= '0;
            err_code_q  <= ERR_NONE;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            sum_q       <= sum_d;
            err_code_q  <= err_code_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
`ifdef UART_FRAME_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Randomized self-checking bench for uart_frame_rx against a frame-level parser model.
module tb_uart_frame_rx;

    localparam int         MAX_LEN = 16;
    localparam logic [7:0] SYNC    = 8'hA5;

    logic       clk;
    logic       rst;
    logic       uart_rx_req;
    logic       uart_rx_ready;
    logic [7:0] uart_rx_data;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;

    uart_frame_rx #(
        .MAX_LEN        (MAX_LEN),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (16'd100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .uart_rx_req   (uart_rx_req),
        .uart_rx_ready (uart_rx_ready),
        .uart_rx_data  (uart_rx_data),
        .m_data        (m_data),
        .m_valid       (m_valid),
        .m_last        (m_last),
        .m_ready       (m_ready),
        .frame_ok      (frame_ok),
        .frame_err     (frame_err),
        .err_code      (err_code)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] srcQ[$];
    logic [7:0] phaseStream[$];
    logic [7:0] seq[$];

    logic [7:0] obsData[$];
    logic       obsLast[$];
    logic [1:0] obsErr[$];
    int         obsOk = 0;

    logic [7:0] expData[$];
    logic       expLast[$];
    logic [1:0] expErr[$];
    int         expOk = 0;

    int         sinkMode = 0;
    int         holdCnt  = 0;
    bit         bpArm    = 0;
    int         stallCount = 0;
    logic [7:0] lastStallData = 8'h00;
    bit         prevStall = 0;
    logic [7:0] prevData = 8'h00;
    logic       prevLast = 1'b0;
    int         cyc = 0;
    int         lastAccCyc = 0;
    int         errCyc = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        srcQ.push_back(b);
        phaseStream.push_back(b);
    endtask

    task automatic sendSeq();
        foreach (seq[i]) applyStimulus(seq[i]);
    endtask

    // Frame with given length; kind 0 = good, 1 = corrupted checksum.
    task automatic sendFrame(input int len, input int kind);
        logic [7:0] s;
        logic [7:0] b;
        s = 8'(len);
        applyStimulus(SYNC);
        applyStimulus(8'(len));
        for (int j = 0; j < len; j++) begin
            b = 8'($urandom_range(0, 255));
            s = s + b;
            applyStimulus(b);
        end
        if (kind == 0) applyStimulus(8'(0) - s);
        else           applyStimulus(8'(0) - s + 8'($urandom_range(1, 255)));
    endtask

    task automatic sendRandomFrame();
        int kind;
        logic [7:0] b;
        repeat ($urandom_range(0, 3)) begin
            b = 8'($urandom_range(0, 255));
            if (b == SYNC) b = 8'h00;
            applyStimulus(b);
        end
        kind = $urandom_range(0, 9);
        if (kind < 6) sendFrame($urandom_range(1, MAX_LEN), 0);
        else if (kind < 8) sendFrame($urandom_range(1, MAX_LEN), 1);
        else begin
            applyStimulus(SYNC);
            if ($urandom_range(0, 1) == 0) applyStimulus(8'h00);
            else applyStimulus(8'($urandom_range(MAX_LEN + 1, 255)));
        end
    endtask

    // Reference parser: walks the byte stream frame by frame.
    task automatic modelParse();
        int i;
        int n;
        int len;
        int s;
        expData.delete();
        expLast.delete();
        expErr.delete();
        expOk = 0;
        i = 0;
        n = phaseStream.size();
        while (i < n) begin
            if (phaseStream[i] != SYNC) begin
                i++;
                continue;
            end
            if (i + 1 >= n) break;
            len = int'(phaseStream[i+1]);
            if (len == 0 || len > MAX_LEN) begin
                expErr.push_back(2'b01);
                i += 2;
                continue;
            end
            if (i + 2 + len >= n) break;
            s = len + int'(phaseStream[i+2+len]);
            for (int j = 0; j < len; j++) s += int'(phaseStream[i+2+j]);
            if (s % 256 == 0) begin
                expOk++;
                for (int j = 0; j < len; j++) begin
                    expData.push_back(phaseStream[i+2+j]);
                    expLast.push_back(j == len - 1);
                end
            end else begin
                expErr.push_back(2'b10);
            end
            i += len + 3;
        end
    endtask

    task automatic clearObs();
        obsData.delete();
        obsLast.delete();
        obsErr.delete();
        obsOk = 0;
        phaseStream.delete();
    endtask

    task automatic runPhase(input string name);
        int budget;
        int idle;
        budget = 0;
        while (srcQ.size() > 0 && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        idle = 0;
        while (idle < 3 && budget < 5000) begin
            @(negedge clk);
            #2;
            if (!m_valid) idle++;
            else idle = 0;
            budget++;
        end
        checkOutput({name, "_done"}, budget < 5000, 1);
        modelParse();
        checkOutput({name, "_okCount"}, obsOk, expOk);
        checkOutput({name, "_errCount"}, obsErr.size(), expErr.size());
        for (int k = 0; k < expErr.size() && k < obsErr.size(); k++)
            checkOutput({name, "_errCode"}, obsErr[k], expErr[k]);
        checkOutput({name, "_byteCount"}, obsData.size(), expData.size());
        for (int k = 0; k < expData.size() && k < obsData.size(); k++) begin
            checkOutput({name, "_data"}, obsData[k], expData[k]);
            checkOutput({name, "_last"}, obsLast[k], expLast[k]);
        end
        clearObs();
    endtask

    // UART side: present the queue head, pop it when the DUT takes it.
    initial begin
        bit acc;
        uart_rx_ready = 1'b0;
        uart_rx_data  = 8'h00;
        forever begin
            @(negedge clk);
            uart_rx_ready = (srcQ.size() > 0);
            uart_rx_data  = uart_rx_ready ? srcQ[0] : 8'h00;
            acc = uart_rx_req && uart_rx_ready;
            @(posedge clk);
            if (acc) void'(srcQ.pop_front());
        end
    end

    // Sink side: ready policy plus a one-shot hold-off after a handshake.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (holdCnt > 0) begin
                m_ready = 1'b0;
                holdCnt--;
            end else if (sinkMode == 0) m_ready = 1'b1;
            else if (sinkMode == 1) m_ready = 1'($urandom_range(0, 1));
            else m_ready = 1'b0;
            if (bpArm && m_valid && m_ready) begin
                holdCnt = 10;
                bpArm = 0;
            end
        end
    end

    // Monitor: collects output events and checks per-cycle protocol rules.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (uart_rx_req && uart_rx_ready && rst) lastAccCyc = cyc;
            if (m_valid) checkOutput("reqLowInOut", uart_rx_req, 0);
            if (frame_ok) begin
                obsOk++;
                checkOutput("validWithOk", m_valid, 1);
            end
            if (frame_err) begin
                obsErr.push_back(err_code);
                errCyc = cyc;
            end
            if (rst && prevStall) begin
                checkOutput("stallValid", m_valid, 1);
                checkOutput("stallData", m_data, prevData);
                checkOutput("stallLast", m_last, prevLast);
                stallCount++;
                lastStallData = m_data;
            end
            if (m_valid && m_ready) begin
                obsData.push_back(m_data);
                obsLast.push_back(m_last);
            end
            prevStall = rst && m_valid && !m_ready;
            prevData  = m_data;
            prevLast  = m_last;
        end
    end

    initial begin
        int budget;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        checkOutput("rstReq", uart_rx_req, 1);
        checkOutput("rstValid", m_valid, 0);
        checkOutput("rstLast", m_last, 0);
        checkOutput("rstOk", frame_ok, 0);
        checkOutput("rstErr", frame_err, 0);
        checkOutput("rstCode", err_code, 0);
        checkOutput("rstData", m_data, 0);
        @(negedge clk);
        rst = 1'b1;
        clearObs();

        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        sendSeq();
        runPhase("good");

        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98};
        sendSeq();
        runPhase("badCsum");
        checkOutput("badCsumHold", err_code, 2'b10);

        seq = '{8'hA5, 8'h00, 8'hA5, 8'h11, 8'hA5, 8'h01, 8'h7E, 8'h81};
        sendSeq();
        runPhase("badLen");

        seq = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h7E, 8'h81};
        sendSeq();
        runPhase("hunt");

        sendFrame(MAX_LEN, 0);
        sendFrame(MAX_LEN, 1);
        runPhase("maxLen");

        stallCount = 0;
        bpArm = 1;
        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97, 8'hA5, 8'h01, 8'h7E, 8'h81};
        sendSeq();
        runPhase("backpressure");
        checkOutput("bpStallCycles", stallCount, 10);
        checkOutput("bpStallData", lastStallData, 8'h22);

        sinkMode = 1;
        for (int r = 0; r < 20; r++) begin
            repeat ($urandom_range(1, 4)) sendRandomFrame();
            runPhase("random");
        end
        sinkMode = 0;

        seq = '{8'hA5, 8'h02, 8'h11};
        sendSeq();
        budget = 0;
        while (srcQ.size() > 0 && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        repeat (300) @(negedge clk);
        #2;
`ifdef UART_FRAME_TIMEOUT_EN
        checkOutput("tmoErrCount", obsErr.size(), 1);
        if (obsErr.size() > 0) checkOutput("tmoCode", obsErr[0], 2'b11);
        checkOutput("tmoDelayOk", (errCyc - lastAccCyc) >= 99 && (errCyc - lastAccCyc) <= 102, 1);
        clearObs();
`else
        checkOutput("noTmoErr", obsErr.size(), 0);
        checkOutput("noTmoValid", m_valid, 0);
        checkOutput("noTmoReq", uart_rx_req, 1);
        applyStimulus(8'h22);
        applyStimulus(8'hCB);
        runPhase("resume");
`endif

        seq = '{8'hA5, 8'h03, 8'h11};
        sendSeq();
        budget = 0;
        while (srcQ.size() > 0 && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #3;
        checkOutput("midRstReq", uart_rx_req, 1);
        checkOutput("midRstValid", m_valid, 0);
        checkOutput("midRstNoErr", obsErr.size(), 0);
        clearObs();
        seq = '{8'hA5, 8'h01, 8'h7E, 8'h81};
        sendSeq();
        runPhase("afterMidRst");

        sinkMode = 2;
        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
        sendSeq();
        budget = 0;
        while (!m_valid && budget < 500) begin
            @(negedge clk);
            #2;
            budget++;
        end
        checkOutput("outReached", m_valid, 1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #3;
        checkOutput("outRstValid", m_valid, 0);
        checkOutput("outRstReq", uart_rx_req, 1);
        checkOutput("outRstNoErr", obsErr.size(), 0);
        clearObs();
        sinkMode = 0;
        seq = '{8'hA5, 8'h01, 8'h7E, 8'h81};
        sendSeq();
        runPhase("afterOutRst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
